// File: rtl/triangle_assembler.sv
// triangle_assembler: groups a one-vertex-per-cycle stream into triangles.
// Supports list, strip and fan topologies. The mode is latched on the first
// vertex of each batch. Each completed triangle is presented as a registered
// single-cycle pulse.
module triangle_assembler #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    input  logic [3:0][31:0]       vertex_in,
    input  logic                   first_in,
    input  logic [1:0]             mode_in,
    output logic                   valid_out,
    output logic [2:0][3:0][31:0]  triangle_out,
    output logic [COUNT_WIDTH-1:0] tri_count_out
);

    typedef enum logic [1:0] {
        MODE_LIST  = 2'd0,
        MODE_STRIP = 2'd1,
        MODE_FAN   = 2'd2
    } mode_t;

    logic [3:0][31:0]      v0_q, v0_d;
    logic [3:0][31:0]      v1_q, v1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  par_q, par_d;
    mode_t                 mode_q, mode_d;
    logic                  emit;
    logic [2:0][3:0][31:0] tri_d;

    // Decide the next buffer contents and whether the incoming vertex closes a triangle
    always_comb begin
        v0_d   = v0_q;
        v1_d   = v1_q;
        cnt_d  = cnt_q;
        par_d  = par_q;
        mode_d = mode_q;
        emit   = 1'b0;
        tri_d  = '0;
        if (valid_in) begin
            if (first_in) begin
                v0_d   = vertex_in;
                cnt_d  = 2'd1;
                par_d  = 1'b0;
                mode_d = (mode_in == 2'd3) ? MODE_LIST : mode_t'(mode_in);
            end else begin
                case (cnt_q)
                    2'd0: begin
                        v0_d  = vertex_in;
                        cnt_d = 2'd1;
                    end
                    2'd1: begin
                        v1_d  = vertex_in;
                        cnt_d = 2'd2;
                    end
                    2'd2: begin
                        emit     = 1'b1;
                        tri_d[0] = v0_q;
                        tri_d[1] = v1_q;
                        tri_d[2] = vertex_in;
                        case (mode_q)
                            MODE_STRIP: begin
                                if (par_q) begin
                                    tri_d[0] = v1_q;
                                    tri_d[1] = v0_q;
                                end
                                v0_d  = v1_q;
                                v1_d  = vertex_in;
                                par_d = ~par_q;
                            end
                            MODE_FAN: begin
                                v1_d = vertex_in;
                            end
                            default: begin
                                cnt_d = 2'd0;
                            end
                        endcase
                    end
                    default: begin
                        cnt_d = 2'd0;
                    end
                endcase
            end
        end
    end

    // Vertex buffers, fill count, strip parity and latched topology
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v0_q   <= '0;
            v1_q   <= '0;
            cnt_q  <= 2'd0;
            par_q  <= 1'b0;
            mode_q <= MODE_LIST;
        end else begin
            v0_q   <= v0_d;
            v1_q   <= v1_d;
            cnt_q  <= cnt_d;
            par_q  <= par_d;
            mode_q <= mode_d;
        end
    end

    // Registered triangle output, one-cycle valid pulse and the wrapping emit counter
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out     <= 1'b0;
            triangle_out  <= '0;
            tri_count_out <= '0;
        end else begin
            valid_out <= emit;
            if (emit) begin
                triangle_out  <= tri_d;
                tri_count_out <= tri_count_out + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_triangle_assembler.sv
// Testbench for triangle_assembler. A reference model built on per-batch
// vertex lists predicts each triangle. A negedge monitor compares the DUT
// outputs against a scoreboard queue. A second instance with a 2-bit counter
// shares the same inputs and is used to exercise counter wrap-around.
module tb_triangle_assembler;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  valid_in = 1'b0;
    logic [3:0][31:0]      vertex_in = '0;
    logic                  first_in = 1'b0;
    logic [1:0]            mode_in = 2'd0;
    logic                  valid_out;
    logic [2:0][3:0][31:0] triangle_out;
    logic [15:0]           tri_count_out;
    logic                  valid_w;
    logic [2:0][3:0][31:0] triangle_w;
    logic [1:0]            count_w;

    typedef struct {
        logic [2:0][3:0][31:0] tri_v;
        logic [15:0]           cnt;
    } exp_t;

    exp_t             expq[$];
    logic [3:0][31:0] batch[$];
    int               model_mode = 0;
    logic [15:0]      model_cnt = '0;
    logic [2:0][3:0][31:0] last_tri = '0;
    logic [15:0]      last_cnt = '0;
    int               n_cmp = 0;
    int               n_fail = 0;

    triangle_assembler #(.COUNT_WIDTH(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .vertex_in(vertex_in), .first_in(first_in), .mode_in(mode_in),
        .valid_out(valid_out), .triangle_out(triangle_out),
        .tri_count_out(tri_count_out)
    );

    triangle_assembler #(.COUNT_WIDTH(2)) dut_w (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .vertex_in(vertex_in), .first_in(first_in), .mode_in(mode_in),
        .valid_out(valid_w), .triangle_out(triangle_w),
        .tri_count_out(count_w)
    );

    // Free-running clock
    always #5 clk_in = ~clk_in;

    function automatic logic [3:0][31:0] mk(input int k);
        logic [3:0][31:0] v;
        for (int i = 0; i < 4; i++) v[i] = 32'(k);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference model: each batch is a list of vertices; triangles are derived
    // from the batch position using the topology rules.
    task automatic modelStep(input logic v, input logic f, input logic [1:0] m, input logic [3:0][31:0] vtx);
        exp_t e;
        int   n;
        bit   do_emit;
        if (!v) return;
        if (f) begin
            batch.delete();
            batch.push_back(vtx);
            model_mode = (m == 2'd3) ? 0 : int'(m);
            return;
        end
        batch.push_back(vtx);
        n = batch.size();
        do_emit = 1'b0;
        if (n >= 3) begin
            do_emit = 1'b1;
            if (model_mode == 1) begin
                if (((n - 3) % 2) == 0) begin
                    e.tri_v[0] = batch[n-3];
                    e.tri_v[1] = batch[n-2];
                end else begin
                    e.tri_v[0] = batch[n-2];
                    e.tri_v[1] = batch[n-3];
                end
                e.tri_v[2] = batch[n-1];
            end else if (model_mode == 2) begin
                e.tri_v[0] = batch[0];
                e.tri_v[1] = batch[n-2];
                e.tri_v[2] = batch[n-1];
            end else begin
                e.tri_v[0] = batch[0];
                e.tri_v[1] = batch[1];
                e.tri_v[2] = batch[2];
                batch.delete();
            end
        end
        if (do_emit) begin
            model_cnt = model_cnt + 16'd1;
            e.cnt = model_cnt;
            expq.push_back(e);
        end
    endtask

    // One clock of stimulus; inputs change 1ns after the rising edge
    task automatic applyStimulus(input logic v, input logic f, input logic [1:0] m, input logic [3:0][31:0] vtx);
        valid_in  = v;
        first_in  = f;
        mode_in   = m;
        vertex_in = vtx;
        @(posedge clk_in);
        modelStep(v, f, m, vtx);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, '0);
    endtask

    // Asynchronous reset between clock edges, with immediate output checks
    task automatic applyReset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        first_in = 1'b0;
        #1;
        checkOutput("reset_valid", 384'(valid_out), 384'(0));
        checkOutput("reset_triangle", 384'(triangle_out), 384'(0));
        checkOutput("reset_count", 384'(tri_count_out), 384'(0));
        checkOutput("reset_count_w", 384'(count_w), 384'(0));
        expq.delete();
        batch.delete();
        model_mode = 0;
        model_cnt  = '0;
        last_tri   = '0;
        last_cnt   = '0;
        @(negedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a pulse appears, otherwise checks hold
    always @(negedge clk_in) begin
        exp_t e;
        if (valid_out) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_pulse: got valid_out=1 required 0, triangle %h", triangle_out);
            end else begin
                e = expq.pop_front();
                checkOutput("triangle", 384'(triangle_out), 384'(e.tri_v));
                checkOutput("count", 384'(tri_count_out), 384'(e.cnt));
                checkOutput("valid_w", 384'(valid_w), 384'(1));
                checkOutput("triangle_w", 384'(triangle_w), 384'(e.tri_v));
                checkOutput("count_w", 384'(count_w), 384'(e.cnt[1:0]));
                last_tri = e.tri_v;
                last_cnt = e.cnt;
            end
        end else if (expq.size() != 0) begin
            e = expq.pop_front();
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL missing_pulse: got valid_out=0 required 1, triangle %h", e.tri_v);
            last_tri = e.tri_v;
            last_cnt = e.cnt;
        end else begin
            checkOutput("hold_triangle", 384'(triangle_out), 384'(last_tri));
            checkOutput("hold_count", 384'(tri_count_out), 384'(last_cnt));
            checkOutput("valid_w_idle", 384'(valid_w), 384'(0));
            checkOutput("hold_count_w", 384'(count_w), 384'(last_cnt[1:0]));
        end
    end

    initial begin
        applyReset();

        $display("[TB] list");
        applyStimulus(1'b1, 1'b1, 2'd0, mk(1));
        for (int k = 2; k <= 4; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        applyStimulus(1'b0, 1'b1, 2'd1, mk(99));
        for (int k = 5; k <= 6; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        idle(2);

        $display("[TB] strip");
        applyStimulus(1'b1, 1'b1, 2'd1, mk(1));
        for (int k = 2; k <= 5; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        idle(2);

        $display("[TB] fan with gaps");
        applyStimulus(1'b1, 1'b1, 2'd2, mk(1));
        for (int k = 2; k <= 6; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        idle(3);
        applyStimulus(1'b1, 1'b0, 2'd0, mk(7));
        idle(2);

        $display("[TB] batch restart");
        applyStimulus(1'b1, 1'b1, 2'd0, mk(1));
        applyStimulus(1'b1, 1'b0, 2'd0, mk(2));
        applyStimulus(1'b1, 1'b1, 2'd1, mk(10));
        applyStimulus(1'b1, 1'b0, 2'd0, mk(11));
        applyStimulus(1'b1, 1'b0, 2'd0, mk(12));
        idle(2);

        $display("[TB] pre-first stream and mode 3");
        applyReset();
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        applyStimulus(1'b1, 1'b1, 2'd3, mk(4));
        for (int k = 5; k <= 7; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        idle(2);

        $display("[TB] async reset mid-strip");
        applyStimulus(1'b1, 1'b1, 2'd1, mk(1));
        for (int k = 2; k <= 4; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        applyReset();
        for (int k = 20; k <= 22; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        idle(2);

        $display("[TB] counter wrap");
        applyReset();
        for (int k = 1; k <= 15; k++) applyStimulus(1'b1, 1'b0, 2'd0, mk(k));
        idle(2);

        $display("[TB] random");
        for (int c = 0; c < 2000; c++) begin
            logic [3:0][31:0] rv;
            for (int i = 0; i < 4; i++) rv[i] = $urandom;
            if (c == 1000) applyReset();
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                          2'($urandom_range(0, 3)), rv);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
